// File: rtl/exec_sequencer.sv
// Run/step/breakpoint sequencer producing a registered one-cycle cpu_en strobe for the MIPS datapath.
// Strobe leaves a flop one cycle after the decision; no backpressure. Breakpoint logic under EXEC_SEQ_BREAKPOINT_EN.
module exec_sequencer #(
  parameter int PRESCALE = 25000000,
  parameter int DEBOUNCE = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_key_n,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  input  logic        cnt_clr,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] instr_cnt
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

  state_t          cur_st;
  state_t          nxt_st;
  logic            run_meta;
  logic            run_s;
  logic            key_meta;
  logic            key_s;
  logic            db_key;
  logic [DB_W-1:0] db_cnt;
  logic            step_req;
  logic [PS_W-1:0] presc;
  logic [PS_W-1:0] presc_nxt;
  logic            tc;
  logic            strobe_nxt;
  logic            run_lock;
  logic            bp_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      run_meta <= run_sw;
      run_s    <= run_meta;
      key_meta <= step_key_n;
      key_s    <= key_meta;
    end
  end

  // Any sample equal to the debounced level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_key   <= 1'b1;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (key_s != db_key) begin
        if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
          db_key   <= key_s;
          db_cnt   <= '0;
          step_req <= db_key;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign tc = (presc == PS_W'(PRESCALE - 1));

`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic first;

  // first lets a run started on the breakpoint PC execute it rather than re-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first <= 1'b0;
    end else if (cur_st == S_HALT && nxt_st == S_RUN) begin
      first <= 1'b1;
    end else if (cur_st == S_RUN && strobe_nxt) begin
      first <= 1'b0;
    end
  end

  assign bp_match = bp_en && (pc == bp_addr) && !first;
  assign bp_hit   = (cur_st == S_BRK);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st   <= S_HALT;
      cpu_en   <= 1'b0;
      presc    <= '0;
      run_lock <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      cpu_en <= strobe_nxt;
      presc  <= presc_nxt;
      // After a step the switch must be cycled low before RUN is re-entered.
      if (nxt_st == S_STEP) begin
        run_lock <= 1'b1;
      end else if (!run_s) begin
        run_lock <= 1'b0;
      end
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_HALT: begin
        if (step_req) begin
          nxt_st = S_STEP;
        end else if (run_s && !run_lock) begin
          nxt_st = S_RUN;
        end
      end
      S_STEP: nxt_st = S_HALT;
      S_RUN: begin
        if (!run_s) begin
          nxt_st = S_HALT;
        end else if (tc && bp_match) begin
          nxt_st = S_BRK;
        end
      end
      S_BRK: begin
        if (step_req) begin
          nxt_st = S_STEP;
        end else if (!run_s) begin
          nxt_st = S_HALT;
        end
      end
      default: nxt_st = S_HALT;
    endcase
  end

  always_comb begin
    strobe_nxt = 1'b0;
    presc_nxt  = '0;
    if (nxt_st == S_STEP) begin
      strobe_nxt = 1'b1;
    end
    if (cur_st == S_RUN && nxt_st == S_RUN) begin
      if (tc) begin
        strobe_nxt = 1'b1;
      end else begin
        presc_nxt = presc + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (cnt_clr) begin
      instr_cnt <= '0;
    end else if (cpu_en) begin
      instr_cnt <= instr_cnt + 16'd1;
    end
  end

  assign state  = cur_st;
  assign halted = (cur_st == S_HALT) || (cur_st == S_BRK);

endmodule
